// File: rtl/edge_stream_buffer_if.sv
// Handshake and data bundle between the edge PEs, the RS port
// and the output-SRAM request path of edge_stream_buffer.
interface edge_stream_buffer_if #(
    parameter int NUM_PE  = 4,
    parameter int FV_SIZE = 16
);
    logic [NUM_PE-1:0]                   edge_sos;
    logic [NUM_PE-1:0]                   edge_eos;
    logic [NUM_PE-1:0]                   edge_done_aggr;
    logic [NUM_PE-1:0]                   edge_wb_en;
    logic [NUM_PE-1:0][1:0][FV_SIZE-1:0] edge_fv;
    logic [NUM_PE-1:0]                   req_grant;
    logic                                RS_available;

    logic                                rs_pkt_sos;
    logic                                rs_pkt_eos;
    logic [1:0][FV_SIZE-1:0]             rs_pkt_fv;

    logic [NUM_PE-1:0]                   bank_busy;
    logic [NUM_PE-1:0]                   outbuff_req;
    logic [NUM_PE-1:0]                   outbuff_sos;
    logic [NUM_PE-1:0]                   outbuff_eos;
    logic [NUM_PE-1:0][1:0][FV_SIZE-1:0] outbuff_fv;

    modport master (
        output edge_sos, edge_eos, edge_done_aggr, edge_wb_en, edge_fv,
        output req_grant, RS_available,
        input  rs_pkt_sos, rs_pkt_eos, rs_pkt_fv,
        input  bank_busy, outbuff_req, outbuff_sos, outbuff_eos, outbuff_fv
    );

    modport slave (
        input  edge_sos, edge_eos, edge_done_aggr, edge_wb_en, edge_fv,
        input  req_grant, RS_available,
        output rs_pkt_sos, rs_pkt_eos, rs_pkt_fv,
        output bank_busy, outbuff_req, outbuff_sos, outbuff_eos, outbuff_fv
    );
endinterface

// File: rtl/edge_stream_buffer.sv
// Per-PE packet capture with streaming to the RS or output SRAM.
// The shared RS port is granted round-robin and held until eos.
module edge_stream_buffer #(
    parameter int NUM_PE  = 4,
    parameter int FV_SIZE = 16,
    parameter int DEPTH   = 8
) (
    input logic                 clk,
    input logic                 reset,
    edge_stream_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        EMPTY,
        FILL,
        WAIT_RS,
        WAIT_OB,
        STREAM_RS,
        STREAM_OB
    } lane_state_e;

    typedef enum logic {
        IDLE,
        BLOCKED
    } top_state_e;

    typedef logic [1:0][FV_SIZE-1:0] fv_t;

    logic [NUM_PE-1:0] rs_req;
    logic [NUM_PE-1:0] masked_req;
    logic [NUM_PE-1:0] rs_grant;
    logic [NUM_PE-1:0] gnt_n;
    logic [NUM_PE-1:0] grant_last;
    logic [NUM_PE-1:0] grant_last_n;
    logic [NUM_PE-1:0] lane_rs_sos;
    logic [NUM_PE-1:0] lane_rs_eos;
    fv_t  [NUM_PE-1:0] lane_rs_fv;
    logic [NUM_PE-1:0] ob_req;
    logic [NUM_PE-1:0] ob_sos;
    logic [NUM_PE-1:0] ob_eos;
    fv_t  [NUM_PE-1:0] ob_fv;
    logic [NUM_PE-1:0] busy;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        lane_state_e   st;
        lane_state_e   st_n;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_n;
        logic [CW-1:0] rd;
        logic [CW-1:0] rd_n;
        logic [CW-1:0] base;
        logic          done;
        logic          done_n;
        logic          wr_en;
        logic [AW-1:0] wr_idx;
        logic          last_beat;
        fv_t           rd_data;
        fv_t           mem [DEPTH];

        assign last_beat = (rd == cnt - CW'(1));
        assign rd_data   = mem[rd[AW-1:0]];

        always_comb begin
            st_n   = st;
            cnt_n  = cnt;
            rd_n   = rd;
            done_n = done;
            wr_en  = 1'b0;
            wr_idx = '0;
            base   = '0;
            unique case (st)
                EMPTY, FILL: begin
                    if (bus.edge_wb_en[i] &&
                        (bus.edge_sos[i] || st == FILL)) begin
                        base   = bus.edge_sos[i] ? '0 : cnt;
                        // beats past DEPTH are dropped, eos still counts
                        wr_en  = (base < CW'(DEPTH));
                        wr_idx = base[AW-1:0];
                        cnt_n  = wr_en ? base + CW'(1) : base;
                        done_n = (done & ~bus.edge_sos[i]) |
                                 bus.edge_done_aggr[i];
                        if (bus.edge_eos[i]) begin
                            st_n = done_n ? WAIT_OB : WAIT_RS;
                            rd_n = '0;
                        end else begin
                            st_n = FILL;
                        end
                    end
                end
                WAIT_RS: begin
                    if (rs_grant[i]) st_n = STREAM_RS;
                end
                WAIT_OB: begin
                    if (bus.req_grant[i]) st_n = STREAM_OB;
                end
                STREAM_RS, STREAM_OB: begin
                    rd_n = rd + CW'(1);
                    if (last_beat) st_n = EMPTY;
                end
                default: st_n = EMPTY;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st   <= EMPTY;
                cnt  <= '0;
                rd   <= '0;
                done <= 1'b0;
            end else begin
                st   <= st_n;
                cnt  <= cnt_n;
                rd   <= rd_n;
                done <= done_n;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_idx] <= bus.edge_fv[i];
        end

        assign rs_req[i]      = (st == WAIT_RS);
        assign lane_rs_sos[i] = (st == STREAM_RS) && (rd == '0);
        assign lane_rs_eos[i] = (st == STREAM_RS) && last_beat;
        assign lane_rs_fv[i]  = (st == STREAM_RS) ? rd_data : '0;
        assign ob_req[i]      = (st == WAIT_OB);
        assign ob_sos[i]      = (st == STREAM_OB) && (rd == '0);
        assign ob_eos[i]      = (st == STREAM_OB) && last_beat;
        assign ob_fv[i]       = (st == STREAM_OB) ? rd_data : '0;
        assign busy[i]        = (st != EMPTY) && (st != FILL);
    end

    top_state_e top;
    top_state_e top_n;
    logic       any_grant;
    logic       any_eos;

    assign any_grant = |rs_grant;
    assign any_eos   = |lane_rs_eos;

    always_comb begin
        top_n        = top;
        grant_last_n = grant_last;
        unique case (top)
            IDLE: begin
                if (any_grant) begin
                    top_n        = BLOCKED;
                    grant_last_n = rs_grant;
                end
            end
            BLOCKED: begin
                if (any_eos) top_n = IDLE;
            end
            default: top_n = IDLE;
        endcase
        // the eos cycle unmasks, so the next grant follows with no gap
        masked_req = rs_req;
        if (any_grant || (top == BLOCKED && !any_eos) ||
            !bus.RS_available) begin
            masked_req = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top        <= IDLE;
            grant_last <= '0;
        end else begin
            top        <= top_n;
            grant_last <= grant_last_n;
        end
    end

    logic [IW-1:0] last_idx;
    logic [IW-1:0] idx_n;
    logic          gnt_found;

    always_comb begin : p_arb
        logic [IW:0] jw;
        gnt_n     = '0;
        idx_n     = last_idx;
        gnt_found = 1'b0;
        jw        = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            jw = {1'b0, last_idx} + (IW+1)'(1) + (IW+1)'(k);
            if (jw >= (IW+1)'(NUM_PE)) jw = jw - (IW+1)'(NUM_PE);
            if (!gnt_found && masked_req[jw[IW-1:0]]) begin
                gnt_n[jw[IW-1:0]] = 1'b1;
                idx_n             = jw[IW-1:0];
                gnt_found         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_grant <= '0;
            last_idx <= IW'(NUM_PE - 1);
        end else begin
            rs_grant <= gnt_n;
            if (gnt_found) last_idx <= idx_n;
        end
    end

    logic rs_sos;
    logic rs_eos;
    fv_t  rs_fv;

    always_comb begin
        rs_sos = 1'b0;
        rs_eos = 1'b0;
        rs_fv  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (grant_last[i]) begin
                rs_sos = rs_sos | lane_rs_sos[i];
                rs_eos = rs_eos | lane_rs_eos[i];
                rs_fv  = rs_fv | lane_rs_fv[i];
            end
        end
    end

    assign bus.rs_pkt_sos  = rs_sos;
    assign bus.rs_pkt_eos  = rs_eos;
    assign bus.rs_pkt_fv   = rs_fv;
    assign bus.bank_busy   = busy;
    assign bus.outbuff_req = ob_req;
    assign bus.outbuff_sos = ob_sos;
    assign bus.outbuff_eos = ob_eos;
    assign bus.outbuff_fv  = ob_fv;
endmodule

// File: tb/tb_edge_stream_buffer.sv
// Bench for edge_stream_buffer: scoreboarded RS / output-SRAM beats
// plus per-scenario timing checks.
module tb_edge_stream_buffer;
    localparam int NUM_PE  = 4;
    localparam int FV_SIZE = 16;
    localparam int DEPTH   = 8;

    typedef struct packed {
        logic [1:0]  lane;
        logic        sos;
        logic        eos;
        logic [15:0] e1;
        logic [15:0] e0;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    edge_stream_buffer_if #(.NUM_PE(NUM_PE), .FV_SIZE(FV_SIZE)) bus ();

    edge_stream_buffer #(
        .NUM_PE (NUM_PE),
        .FV_SIZE(FV_SIZE),
        .DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rs_eos_cyc = 0;
    beat_t rs_q[$];
    beat_t ob_q[$];
    bit rs_in;
    bit [NUM_PE-1:0] ob_in;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: every beat seen on RS or OB must match the queue head
    always @(negedge clk) begin
        beat_t exp;
        if (reset) begin
            rs_in = 1'b0;
            ob_in = '0;
        end else begin
            if (bus.rs_pkt_sos || bus.rs_pkt_eos || rs_in ||
                bus.rs_pkt_fv != '0) begin
                n_tests++;
                if (rs_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rs_beat: got sos=%0b eos=%0b fv=%h, required no beat",
                             bus.rs_pkt_sos, bus.rs_pkt_eos, bus.rs_pkt_fv);
                end else begin
                    exp = rs_q.pop_front();
                    if ({bus.rs_pkt_sos, bus.rs_pkt_eos, bus.rs_pkt_fv} !==
                        {exp.sos, exp.eos, exp.e1, exp.e0}) begin
                        n_fail++;
                        $display("FAIL rs_beat: got sos=%0b eos=%0b fv=%h, required sos=%0b eos=%0b fv=%h%h (lane %0d)",
                                 bus.rs_pkt_sos, bus.rs_pkt_eos, bus.rs_pkt_fv,
                                 exp.sos, exp.eos, exp.e1, exp.e0, exp.lane);
                    end
                end
                if (bus.rs_pkt_eos) last_rs_eos_cyc = cyc;
                rs_in = !bus.rs_pkt_eos;
            end
            for (int i = 0; i < NUM_PE; i++) begin
                if (bus.outbuff_sos[i] || bus.outbuff_eos[i] || ob_in[i] ||
                    bus.outbuff_fv[i] != '0) begin
                    n_tests++;
                    if (ob_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ob_beat: lane %0d got fv=%h, required no beat",
                                 i, bus.outbuff_fv[i]);
                    end else begin
                        exp = ob_q.pop_front();
                        if ({2'(i), bus.outbuff_sos[i], bus.outbuff_eos[i],
                             bus.outbuff_fv[i]} !== exp) begin
                            n_fail++;
                            $display("FAIL ob_beat: lane %0d got sos=%0b eos=%0b fv=%h, required lane %0d sos=%0b eos=%0b fv=%h%h",
                                     i, bus.outbuff_sos[i], bus.outbuff_eos[i],
                                     bus.outbuff_fv[i], exp.lane, exp.sos,
                                     exp.eos, exp.e1, exp.e0);
                        end
                    end
                    ob_in[i] = !bus.outbuff_eos[i];
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.edge_sos       = '0;
        bus.edge_eos       = '0;
        bus.edge_done_aggr = '0;
        bus.edge_wb_en     = '0;
        bus.edge_fv        = '0;
        bus.req_grant      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        bus.RS_available = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rs_q.delete();
        ob_q.delete();
        @(posedge clk);
        #1;
    endtask

    // drives n beats on every lane in mask, then queues the expected output
    task automatic drive_pkts(input logic [NUM_PE-1:0] mask, input int n,
                              input bit done);
        beat_t b;
        int    kept;
        kept = (n < DEPTH) ? n : DEPTH;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NUM_PE; i++) begin
                bus.edge_wb_en[i]     = mask[i];
                bus.edge_sos[i]       = mask[i] && (k == 0);
                bus.edge_eos[i]       = mask[i] && (k == n - 1);
                bus.edge_done_aggr[i] = mask[i] && done && (k == n - 1);
                bus.edge_fv[i][0]     = 16'hA000 | 16'(i << 8) | 16'(k);
                bus.edge_fv[i][1]     = 16'h5000 | 16'(i << 8) | 16'(k);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        for (int i = 0; i < NUM_PE; i++) begin
            if (mask[i]) begin
                for (int k = 0; k < kept; k++) begin
                    b.lane = 2'(i);
                    b.sos  = (k == 0);
                    b.eos  = (k == kept - 1);
                    b.e0   = 16'hA000 | 16'(i << 8) | 16'(k);
                    b.e1   = 16'h5000 | 16'(i << 8) | 16'(k);
                    if (done) ob_q.push_back(b);
                    else rs_q.push_back(b);
                end
            end
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (rs_q.size() == 0 && ob_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.bank_busy, bus.outbuff_req, bus.outbuff_sos, bus.outbuff_eos,
             bus.outbuff_fv, bus.rs_pkt_sos, bus.rs_pkt_eos, bus.rs_pkt_fv}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b obreq=%b rs_fv=%h, required all 0",
                     bus.bank_busy, bus.outbuff_req, bus.rs_pkt_fv);
        end
        do_reset();
        n_tests++;
        if ({bus.bank_busy, bus.outbuff_req, bus.rs_pkt_sos} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b obreq=%b sos=%b, required 0",
                     bus.bank_busy, bus.outbuff_req, bus.rs_pkt_sos);
        end
    endtask

    task automatic test_rs_basic();
        int t0;
        do_reset();
        drive_pkts(4'b0001, 3, 1'b0);
        t0 = cyc;
        n_tests++;
        if (bus.bank_busy !== 4'b0001) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 0001", bus.bank_busy);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_pkt_sos !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_sos: got %b, required 0", bus.rs_pkt_sos);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_pkt_sos !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sos_time: got %b, required 1", bus.rs_pkt_sos);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.rs_pkt_eos, bus.bank_busy[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_eos: got eos=%b busy=%b, required 1 1",
                     bus.rs_pkt_eos, bus.bank_busy[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.bank_busy !== 4'b0000 || last_rs_eos_cyc - t0 !== 4) begin
            n_fail++;
            $display("FAIL basic_done: got busy=%b eos_lat=%0d, required 0000 4",
                     bus.bank_busy, last_rs_eos_cyc - t0);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        drive_pkts(4'b1111, 2, 1'b0);
        t0 = cyc;
        n_tests++;
        if (bus.bank_busy !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b, required 1111", bus.bank_busy);
        end
        wait_drain(60);
        @(posedge clk);
        #1;
        n_tests++;
        if (rs_q.size() != 0 || last_rs_eos_cyc - t0 !== 12 ||
            bus.bank_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_timing: got left=%0d last_eos=%0d busy=%b, required 0 12 0000",
                     rs_q.size(), last_rs_eos_cyc - t0, bus.bank_busy);
        end
    endtask

    task automatic test_ob_path();
        do_reset();
        drive_pkts(4'b0100, 3, 1'b1);
        n_tests++;
        if ({bus.outbuff_req, bus.bank_busy} !== 8'b0100_0100) begin
            n_fail++;
            $display("FAIL ob_req: got req=%b busy=%b, required 0100 0100",
                     bus.outbuff_req, bus.bank_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.outbuff_req !== 4'b0100 || bus.outbuff_sos !== 4'b0000) begin
            n_fail++;
            $display("FAIL ob_hold: got req=%b sos=%b, required 0100 0000",
                     bus.outbuff_req, bus.outbuff_sos);
        end
        bus.req_grant = 4'b0100;
        @(posedge clk);
        #1;
        bus.req_grant = 4'b0000;
        n_tests++;
        if (bus.outbuff_sos !== 4'b0100 || bus.outbuff_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL ob_start: got sos=%b req=%b, required 0100 0000",
                     bus.outbuff_sos, bus.outbuff_req);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.bank_busy !== 4'b0000 || ob_q.size() != 0) begin
            n_fail++;
            $display("FAIL ob_done: got busy=%b left=%0d, required 0000 0",
                     bus.bank_busy, ob_q.size());
        end
    endtask

    task automatic test_rs_avail();
        do_reset();
        bus.RS_available = 1'b0;
        drive_pkts(4'b0010, 2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (bus.bank_busy !== 4'b0010 || bus.rs_pkt_sos !== 1'b0) begin
            n_fail++;
            $display("FAIL avail_block: got busy=%b sos=%b, required 0010 0",
                     bus.bank_busy, bus.rs_pkt_sos);
        end
        bus.RS_available = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_pkt_sos !== 1'b0) begin
            n_fail++;
            $display("FAIL avail_grant: got sos=%b, required 0", bus.rs_pkt_sos);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_pkt_sos !== 1'b1 || bus.rs_pkt_fv[0] !== 16'hA100) begin
            n_fail++;
            $display("FAIL avail_stream: got sos=%b fv0=%h, required 1 a100",
                     bus.rs_pkt_sos, bus.rs_pkt_fv[0]);
        end
        wait_drain(20);
        n_tests++;
        if (rs_q.size() != 0) begin
            n_fail++;
            $display("FAIL avail_drain: got %0d left, required 0", rs_q.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive_pkts(4'b1000, 10, 1'b0);
        wait_drain(30);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (rs_q.size() != 0 || bus.bank_busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_drain: got left=%0d busy=%b, required 0 0000",
                     rs_q.size(), bus.bank_busy);
        end
        drive_pkts(4'b0001, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.rs_pkt_sos, bus.rs_pkt_eos} !== 2'b11) begin
            n_fail++;
            $display("FAIL one_beat: got sos=%b eos=%b, required 1 1",
                     bus.rs_pkt_sos, bus.rs_pkt_eos);
        end
        wait_drain(10);
        n_tests++;
        if (rs_q.size() != 0) begin
            n_fail++;
            $display("FAIL one_drain: got %0d left, required 0", rs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        drive_pkts(4'b0001, 6, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rs_pkt_sos) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_start: got no sos, required sos within 10 cycles");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        rs_q.delete();
        n_tests++;
        if ({bus.bank_busy, bus.rs_pkt_sos, bus.rs_pkt_eos, bus.rs_pkt_fv,
             bus.outbuff_req} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b rs_fv=%h, required all 0",
                     bus.bank_busy, bus.rs_pkt_fv);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive_pkts(4'b0011, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_pkt_sos !== 1'b1 || bus.rs_pkt_fv[0] !== 16'hA000) begin
            n_fail++;
            $display("FAIL mid_priority: got sos=%b fv0=%h, required 1 a000",
                     bus.rs_pkt_sos, bus.rs_pkt_fv[0]);
        end
        wait_drain(30);
        n_tests++;
        if (rs_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_drain: got %0d left, required 0", rs_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        bus.RS_available = 1'b1;
        test_reset();
        test_rs_basic();
        test_back_to_back();
        test_ob_path();
        test_rs_avail();
        test_overflow();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at 200000, required finish");
        $fatal(1, "timeout");
    end
endmodule
